// File: rtl/program_loader.sv
// Boot loader: pulls a length-prefixed, little-endian word stream from a UART Lite
// over AXI4-Lite reads into instruction BRAM, then releases the core. Option: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned MEMORY_WORDS = 32768
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] s_axi_araddr,
  output logic        s_axi_arvalid,
  input  logic        s_axi_arready,
  input  logic [31:0] s_axi_rdata,
  input  logic [1:0]  s_axi_rresp,
  input  logic        s_axi_rvalid,
  output logic        s_axi_rready,
  output logic        p_we,
  output logic [14:0] p_addr,
  output logic [31:0] p_wdata,
  output logic        core_run,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] LIMIT     = 32'(MEMORY_WORDS);
  localparam logic [31:0] ADDR_RX   = 32'h0000_0000;
  localparam logic [31:0] ADDR_STAT = 32'h0000_0008;

  typedef enum logic [3:0] {
    IDLE, ST_AR, ST_R, ST_CHK, RX_AR, RX_R, PUSH, WRITE, FIN, FAIL
  } state_t;

  // Which word of the stream the assembler is currently building.
  typedef enum logic [1:0] {
    PH_HDR, PH_DATA, PH_CSUM
  } phase_t;

  state_t      r_state, w_next;
  phase_t      r_phase, w_phase_next;
  logic        r_status;
  logic [7:0]  r_rx_byte;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_asm;
  logic [15:0] r_index;
  logic [15:0] r_n;

  logic        w_last_word;
  logic        w_hdr_big;
  logic        w_hdr_zero;

  assign w_last_word = ((r_index + 16'd1) == r_n);
  assign w_hdr_big   = (r_asm > LIMIT);
  assign w_hdr_zero  = (r_asm == '0);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_xor;
  logic        w_csum_ok;
  assign w_csum_ok = (r_asm == r_xor);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= PH_HDR;
    end else begin
      r_state <= w_next;
      r_phase <= w_phase_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_phase_next = r_phase;
    case (r_state)
      IDLE:   w_next = ST_AR;
      ST_AR:  if (s_axi_arready) w_next = ST_R;
      ST_R:   if (s_axi_rvalid)  w_next = ST_CHK;
      ST_CHK: w_next = r_status ? RX_AR : ST_AR;
      RX_AR:  if (s_axi_arready) w_next = RX_R;
      RX_R:   if (s_axi_rvalid)  w_next = PUSH;
      PUSH:   w_next = (r_byte_cnt == 2'd3) ? WRITE : ST_AR;
      WRITE: begin
        case (r_phase)
          PH_HDR: begin
            if (w_hdr_big) begin
              w_next = FAIL;
            end else if (w_hdr_zero) begin
`ifdef LOADER_CHECKSUM_EN
              w_next       = ST_AR;
              w_phase_next = PH_CSUM;
`else
              w_next = FIN;
`endif
            end else begin
              w_next       = ST_AR;
              w_phase_next = PH_DATA;
            end
          end
          PH_DATA: begin
            if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
              w_next       = ST_AR;
              w_phase_next = PH_CSUM;
`else
              w_next = FIN;
`endif
            end else begin
              w_next = ST_AR;
            end
          end
          default: begin
`ifdef LOADER_CHECKSUM_EN
            w_next = w_csum_ok ? FIN : FAIL;
`else
            w_next = FAIL;
`endif
          end
        endcase
      end
      FIN:     w_next = FIN;
      FAIL:    w_next = FAIL;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status   <= 1'b0;
      r_rx_byte  <= '0;
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_index    <= '0;
      r_n        <= '0;
    end else begin
      if (r_state == ST_R && s_axi_rvalid) r_status <= s_axi_rdata[0];
      if (r_state == RX_R && s_axi_rvalid) r_rx_byte <= s_axi_rdata[7:0];
      // Shifting in from the top leaves the first byte of each word in bits 7:0.
      if (r_state == PUSH) begin
        r_asm      <= {r_rx_byte, r_asm[31:8]};
        r_byte_cnt <= r_byte_cnt + 2'd1;
      end
      if (r_state == WRITE) begin
        if (r_phase == PH_HDR)  r_n     <= r_asm[15:0];
        if (r_phase == PH_DATA) r_index <= r_index + 16'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xor <= '0;
    end else if (r_state == WRITE && r_phase == PH_DATA) begin
      r_xor <= r_xor ^ r_asm;
    end
  end
`endif

  always_comb begin
    s_axi_araddr  = (r_state == ST_AR) ? ADDR_STAT : ADDR_RX;
    s_axi_arvalid = (r_state == ST_AR) || (r_state == RX_AR);
    s_axi_rready  = (r_state == ST_R)  || (r_state == RX_R);
    p_we          = (r_state == WRITE) && (r_phase == PH_DATA);
    p_addr        = r_index[14:0];
    p_wdata       = r_asm;
    done          = (r_state == FIN);
    core_run      = (r_state == FIN);
    err           = (r_state == FAIL);
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a UART Lite read-slave model feeds byte streams
// from a vector table; BRAM writes and AXI traffic are logged and compared.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid, arready, rready, rvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        p_we;
  logic [14:0] p_addr;
  logic [31:0] p_wdata;
  logic        core_run, done, err;

  always #5 clk = ~clk;

  assign rresp = 2'b10;

  program_loader #(.MEMORY_WORDS(32768)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .p_we          (p_we),
    .p_addr        (p_addr),
    .p_wdata       (p_wdata),
    .core_run      (core_run),
    .done          (done),
    .err           (err)
  );

  logic [7:0]  stream [0:63];
  int unsigned stream_len;
  int unsigned cfg_zero_polls;

  logic        pend;
  logic [31:0] pend_data;
  int unsigned pos, zero_left, rx_hs, stat_pre, wr_cnt, rx_at_wr, busy_after;
  logic [14:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];

  // Slave: arready one cycle after arvalid, rvalid one cycle after the AR handshake.
  always @(posedge clk) begin
    if (rst) begin
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      pend       <= 1'b0;
      pend_data  <= '0;
      pos        <= 0;
      zero_left  <= cfg_zero_polls;
      rx_hs      <= 0;
      stat_pre   <= 0;
      wr_cnt     <= 0;
      rx_at_wr   <= 0;
      busy_after <= 0;
    end else begin
      arready <= arvalid && !arready && !pend;
      if (arvalid && arready) begin
        pend <= 1'b1;
        if (araddr == 32'h8) begin
          if (rx_hs == 0) stat_pre <= stat_pre + 1;
          if (zero_left != 0) begin
            zero_left <= zero_left - 1;
            pend_data <= 32'h0;
          end else begin
            pend_data <= (pos < stream_len) ? 32'h1 : 32'h0;
          end
        end else begin
          rx_hs     <= rx_hs + 1;
          pend_data <= {24'hA5C3F0, (pos < 64) ? stream[pos] : 8'h00};
          pos       <= pos + 1;
        end
      end
      if (pend && !rvalid) begin
        rvalid <= 1'b1;
        rdata  <= pend_data;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        pend   <= 1'b0;
      end
      if (p_we) begin
        if (wr_cnt < 8) begin
          wr_addr[wr_cnt] <= p_addr;
          wr_data[wr_cnt] <= p_wdata;
        end
        if (wr_cnt == 0) rx_at_wr <= rx_hs;
        wr_cnt <= wr_cnt + 1;
      end
      if (arvalid && (done || err)) busy_after <= busy_after + 1;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int unsigned      nw;
    logic [0:5][31:0] w;
    int unsigned      zp;
    logic             ed;
    logic             ee;
    int unsigned      ewr;
    logic [31:0]      e0;
    logic [31:0]      e1;
    int unsigned      esp;
    int unsigned      erx;
  } vec_t;

  function automatic vec_t mk(input int unsigned nw, input logic [0:5][31:0] w,
                              input int unsigned zp, input logic ed, input logic ee,
                              input int unsigned ewr, input logic [31:0] e0,
                              input logic [31:0] e1, input int unsigned esp,
                              input int unsigned erx);
    vec_t v;
    v.nw = nw; v.w = w; v.zp = zp; v.ed = ed; v.ee = ee;
    v.ewr = ewr; v.e0 = e0; v.e1 = e1; v.esp = esp; v.erx = erx;
    return v;
  endfunction

  task automatic load_stream(input vec_t v);
    for (int unsigned k = 0; k < 64; k++) stream[k] = 8'h00;
    for (int unsigned k = 0; k < v.nw; k++)
      for (int unsigned b = 0; b < 4; b++)
        stream[4*k+b] = v.w[k][8*b +: 8];
    stream_len     = 4 * v.nw;
    cfg_zero_polls = v.zp;
  endtask

  task automatic reset_and_start(input string tag);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk({tag, ".rst_out"},
        {araddr[23:0], arvalid, rready, p_we, p_addr[4:0]} | p_wdata | {29'd0, core_run, done, err},
        32'h0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk({tag, ".start"}, {arvalid, araddr[30:0]}, 32'h8000_0008);
  endtask

  task automatic wait_end(input int unsigned budget);
    int unsigned cyc;
    cyc = 0;
    while (!(done || err) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (20) @(negedge clk);
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    stream_len = 0;
    cfg_zero_polls = 0;

`ifdef LOADER_CHECKSUM_EN
    vecs.push_back(mk(4, {32'd2, 32'h00100513, 32'h0000006F, 32'h0010057C, 64'd0}, 0, 1, 0, 2, 32'h00100513, 32'h0000006F, 1, 8));
    vecs.push_back(mk(4, {32'd2, 32'h00100513, 32'h0000006F, 32'h0010057C, 64'd0}, 5, 1, 0, 2, 32'h00100513, 32'h0000006F, 6, 8));
    vecs.push_back(mk(1, {32'h00008001, 160'd0}, 0, 0, 1, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(2, {32'd0, 32'd0, 128'd0}, 0, 1, 0, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(3, {32'd1, 32'hDEADBEEF, 32'hDEADBEEF, 96'd0}, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0, 1, 8));
    vecs.push_back(mk(1, {32'h00008000, 160'd0}, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(5, {32'd3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'd0}, 2, 1, 0, 3, 32'h11223344, 32'h55667788, 3, 8));
    vecs.push_back(mk(4, {32'd2, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 64'd0}, 0, 1, 0, 2, 32'h0000FFFF, 32'hFFFF0000, 1, 8));
    vecs.push_back(mk(4, {32'd2, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFE, 64'd0}, 0, 0, 1, 2, 32'h0000FFFF, 32'hFFFF0000, 1, 8));
`else
    vecs.push_back(mk(3, {32'd2, 32'h00100513, 32'h0000006F, 96'd0}, 0, 1, 0, 2, 32'h00100513, 32'h0000006F, 1, 8));
    vecs.push_back(mk(3, {32'd2, 32'h00100513, 32'h0000006F, 96'd0}, 5, 1, 0, 2, 32'h00100513, 32'h0000006F, 6, 8));
    vecs.push_back(mk(1, {32'h00008001, 160'd0}, 0, 0, 1, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(1, {32'd0, 160'd0}, 0, 1, 0, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(2, {32'd1, 32'hDEADBEEF, 128'd0}, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0, 1, 8));
    vecs.push_back(mk(1, {32'h00008000, 160'd0}, 0, 0, 0, 0, 32'h0, 32'h0, 1, 0));
    vecs.push_back(mk(4, {32'd3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 64'd0}, 2, 1, 0, 3, 32'h11223344, 32'h55667788, 3, 8));
`endif

    for (int unsigned i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      load_stream(vecs[i]);
      reset_and_start(tag);
      wait_end(1500);
      chk({tag, ".done"}, {31'd0, done}, {31'd0, vecs[i].ed});
      chk({tag, ".err"}, {31'd0, err}, {31'd0, vecs[i].ee});
      chk({tag, ".core_run"}, {31'd0, core_run}, {31'd0, vecs[i].ed});
      chk({tag, ".writes"}, wr_cnt, vecs[i].ewr);
      chk({tag, ".stat_reads"}, stat_pre, vecs[i].esp);
      chk({tag, ".rx_at_first_we"}, rx_at_wr, vecs[i].erx);
      chk({tag, ".ar_after_end"}, busy_after, 32'd0);
      if (vecs[i].ewr >= 1) chk({tag, ".w0"}, wr_data[0], vecs[i].e0);
      if (vecs[i].ewr >= 2) chk({tag, ".w1"}, wr_data[1], vecs[i].e1);
      for (int unsigned k = 0; k < wr_cnt && k < 8; k++)
        chk($sformatf("%s.addr%0d", tag, k), {17'd0, wr_addr[k]}, k);
    end

    // Restart after a 1-cycle reset pulse in the middle of data word 0.
    begin
      int unsigned cyc;
      vec_t v;
`ifdef LOADER_CHECKSUM_EN
      v = mk(3, {32'd1, 32'hDEADBEEF, 32'hDEADBEEF, 96'd0}, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0, 1, 8);
`else
      v = mk(2, {32'd1, 32'hDEADBEEF, 128'd0}, 0, 1, 0, 1, 32'hDEADBEEF, 32'h0, 1, 8);
`endif
      load_stream(v);
      reset_and_start("midrst");
      cyc = 0;
      while (rx_hs < 7 && cyc < 1000) begin
        @(negedge clk);
        cyc++;
      end
      chk("midrst.reached_byte6", {31'd0, rx_hs >= 7}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      wait_end(1500);
      chk("midrst.done", {31'd0, done}, 32'd1);
      chk("midrst.err", {31'd0, err}, 32'd0);
      chk("midrst.writes", wr_cnt, 32'd1);
      chk("midrst.addr0", {17'd0, wr_addr[0]}, 32'd0);
      chk("midrst.w0", wr_data[0], 32'hDEADBEEF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter MEMORY_WORDS, default 32768, the instruction BRAM capacity in 32-bit words.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have AXI4-Lite read-master ports: s_axi_araddr out 32, s_axi_arvalid out 1, s_axi_arready in 1, s_axi_rdata in 32, s_axi_rresp in 2, s_axi_rvalid in 1, s_axi_rready out 1; these connect to the UART Lite (RX FIFO at 0x0, status at 0x8).
REQ-005 SHALL have BRAM write ports: p_we out 1, p_addr out 15 (word address), p_wdata out 32.
REQ-006 SHALL have port core_run, out 1: high means the core may leave reset.
REQ-007 SHALL have ports done out 1 (load finished) and err out 1 (load aborted).

Function
REQ-008 SHALL use these states: IDLE, ST_AR, ST_R, ST_CHK, RX_AR, RX_R, PUSH, WRITE, FIN, FAIL.
REQ-009 SHALL go IDLE->ST_AR one cycle after rst deasserts.
REQ-010 ST_AR: SHALL drive araddr=8 and arvalid=1, hold them until arready, then clear arvalid, set rready=1, and go to ST_R.
REQ-011 ST_R: SHALL hold rready until rvalid, then clear rready, latch rdata as status, and go to ST_CHK.
REQ-012 ST_CHK: SHALL go to RX_AR if status[0]=1, else to ST_AR (re-poll; no idle cycles required).
REQ-013 RX_AR/RX_R: SHALL follow the same handshake as ST_AR/ST_R with araddr=0, latch rdata[7:0], and go to PUSH.
REQ-014 rresp SHALL be ignored.
REQ-015 Byte stream: the first 4 bytes SHALL form word count N, little-endian; then N words SHALL follow, each little-endian (first byte -> bits 7:0).
REQ-016 PUSH SHALL shift the byte into a 32-bit assembler and increment a 2-bit byte counter.
REQ-017 After byte 3 of a word, PUSH SHALL go to WRITE; otherwise it SHALL go to ST_AR.
REQ-018 WRITE for the header SHALL latch N.
REQ-019 If N > MEMORY_WORDS, WRITE SHALL go to FAIL.
REQ-020 If N=0, WRITE SHALL go to FIN.
REQ-021 For any other header value, WRITE SHALL go to ST_AR.
REQ-022 WRITE for a data word SHALL assert p_we for exactly 1 cycle with p_addr = word index (starting at 0) and p_wdata = the assembled word.
REQ-023 After a data-word write, the word index SHALL increment, and WRITE SHALL go to FIN when index+1 = N, else to ST_AR.
REQ-024 p_we SHALL be 0 in every state except WRITE for a data word.
REQ-025 FIN SHALL set done=1 and core_run=1; both SHALL stay high until rst, and the block SHALL issue no further AXI traffic.
REQ-026 FAIL SHALL set err=1 and keep core_run=0 until rst, with no further AXI traffic.
REQ-027 Word index and N SHALL be 16 bits wide, so that N=32768 is representable; p_addr SHALL be index[14:0].
REQ-028 A handshake in flight SHALL be abandoned on rst; the slave is expected to tolerate this.

Reset
REQ-029 On rst=1 at a clk edge, all outputs SHALL be 0: araddr, arvalid, rready, p_we, p_addr, p_wdata, core_run, done, err.
REQ-030 On rst=1 at a clk edge, state SHALL be IDLE and the byte counter, index, N and assembler SHALL all be 0.
REQ-031 rst asserted mid-load SHALL restart the load from the header; previously written BRAM words are not cleared.

Configuration
REQ-032 Macro LOADER_CHECKSUM_EN: when defined, after the N data words one extra 4-byte word SHALL be received, compared with the XOR of all N data words, and checked in WRITE.
REQ-033 With LOADER_CHECKSUM_EN: on a checksum match, WRITE SHALL go to FIN; on a mismatch, WRITE SHALL go to FAIL.
REQ-034 With LOADER_CHECKSUM_EN: the checksum word SHALL never be written to BRAM.
REQ-035 With LOADER_CHECKSUM_EN and N=0: the checksum SHALL be 0x00000000.
REQ-036 Without LOADER_CHECKSUM_EN: no checksum word SHALL be expected, and err SHALL be set only by the REQ-019 overflow case.

Verification
REQ-037 Stream 02 00 00 00 | 13 05 10 00 | 6F 00 00 00, slave arready/rvalid 1 cycle after valid -> p_we twice: addr0=0x00100513, addr1=0x0000006F; then done=1, core_run=1, err=0.
REQ-038 Status returns 0x0 for 5 polls, then 0x1 -> exactly 6 status reads (araddr=8) precede the first araddr=0 read; no p_we before the 4th data byte.
REQ-039 Header 01 80 00 00 (N=32769) -> err=1, core_run=0, no p_we, arvalid stays 0 afterward.
REQ-040 Header 00 00 00 00 -> done=1 with zero BRAM writes (checksum build: after checksum 00 00 00 00).
REQ-041 rst pulsed for 1 cycle after the 2nd data byte of word 0, then a full stream of N=1 word 0xDEADBEEF -> single write addr0=0xDEADBEEF, done=1.
REQ-042 LOADER_CHECKSUM_EN, N=2 words 0x0000FFFF and 0xFFFF0000 -> checksum 0xFFFFFFFF gives done=1; checksum 0xFFFFFFFE gives err=1 and core_run=0.
